// File: rtl/collide_scheduler.sv
// collide_scheduler
//   Sweeps every lattice cell once per pass: reads each cell from BRAM, hands
//   the densities to the collision stage, and writes the collided result back
//   to the same address when the collision stage reports it done. Addresses of
//   cells sent to the collision stage wait in a small FIFO, so results must
//   come back in issue order.
//
// Ports
//   clk_in          single clock, posedge
//   rst_in          synchronous active-high reset
//   start_in        one-cycle pulse, starts a sweep (honoured only when idle)
//   busy_out        high from sweep accept until the done cycle inclusive
//   done_out        one-cycle pulse at sweep completion
//   err_out         sticky: a collision result arrived with no address queued
//   bram_raddr_out  BRAM read address
//   bram_rdata_in   BRAM read data, 9 densities, element k at [8k+7:8k]
//   bram_waddr_out  BRAM write address
//   bram_wdata_out  BRAM write data
//   bram_we_out     BRAM write enable
//   coll_data_out   densities to the collision stage
//   coll_valid_out  coll_data_out valid
//   coll_data_in    collided densities from the collision stage
//   coll_done_in    coll_data_in valid
//
// state  | meaning
// IDLE   | waiting for start_in
// ISSUE  | issuing one read per cycle, throttled by FIFO room
// DRAIN  | all reads issued, waiting for outstanding results
// FINISH | one-cycle done pulse
module collide_scheduler #(
  parameter int GRID_CELLS   = 4800,
  parameter int ADDR_WIDTH   = 13,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out,
  output logic [ADDR_WIDTH-1:0] bram_raddr_out,
  input  logic [8:0][7:0]       bram_rdata_in,
  output logic [ADDR_WIDTH-1:0] bram_waddr_out,
  output logic [8:0][7:0]       bram_wdata_out,
  output logic                  bram_we_out,
  output logic [8:0][7:0]       coll_data_out,
  output logic                  coll_valid_out,
  input  logic [8:0][7:0]       coll_data_in,
  input  logic                  coll_done_in
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(GRID_CELLS - 1);
  localparam logic [PW:0]           OCC_ONE   = 1;

  logic [1:0]              state;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   push_addr;
  logic [BRAM_LATENCY-1:0] vld_sr;
  logic [ADDR_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             occ;
  logic                    err_q;

  logic [31:0] inflight;
  logic [31:0] load;
  logic        issue;
  logic        emerge;
  logic        pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + 32'(vld_sr[i]);
    end
  end

  // Reads in flight are counted against FIFO room: the collision stage cannot
  // be stalled, so every read issued must already own a FIFO slot.
  assign load   = 32'(occ) + inflight;
  assign issue  = (state == S_ISSUE) && (load < 32'(FIFO_DEPTH));
  assign emerge = vld_sr[BRAM_LATENCY-1];
  assign pop    = coll_done_in && (occ != '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      push_addr <= '0;
      vld_sr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_sr[0] <= issue;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end

      // Reads return in issue order, so a counter names the emerging cell.
      if (emerge) begin
        push_addr <= push_addr + ADDR_WIDTH'(1);
        wr_ptr    <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({emerge, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase

      if (coll_done_in && (occ == '0)) begin
        err_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_in) begin
            state     <= S_ISSUE;
            rd_addr   <= '0;
            push_addr <= '0;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (rd_addr == LAST_CELL) begin
              state <= S_DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && (occ == '0) && !coll_done_in) begin
            state <= S_FINISH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (emerge) begin
      fifo_mem[wr_ptr] <= push_addr;
    end
  end

  // Data outputs are gated by their valids so they read zero when idle or in reset.
  assign bram_raddr_out = rd_addr;
  assign bram_we_out    = pop;
  assign bram_waddr_out = pop ? fifo_mem[rd_ptr] : '0;
  assign bram_wdata_out = pop ? coll_data_in : '0;
  assign coll_valid_out = emerge;
  assign coll_data_out  = emerge ? bram_rdata_in : '0;
  assign err_out        = err_q;
  assign busy_out       = (state != S_IDLE);
  assign done_out       = (state == S_FINISH);

endmodule

// File: tb/tb_collide_scheduler.sv
module tb_collide_scheduler;

  localparam int GC   = 8;
  localparam int AW   = 3;
  localparam int BL   = 2;
  localparam int FD   = 4;
  localparam int CDLY = 22;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          busy_out, done_out, err_out;
  logic [AW-1:0] bram_raddr_out, bram_waddr_out;
  logic [8:0][7:0] bram_rdata_in, bram_wdata_out, coll_data_out, coll_data_in;
  logic          bram_we_out, coll_valid_out, coll_done_in;

  collide_scheduler #(
    .GRID_CELLS(GC), .ADDR_WIDTH(AW), .BRAM_LATENCY(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
    .bram_raddr_out(bram_raddr_out), .bram_rdata_in(bram_rdata_in),
    .bram_waddr_out(bram_waddr_out), .bram_wdata_out(bram_wdata_out),
    .bram_we_out(bram_we_out), .coll_data_out(coll_data_out),
    .coll_valid_out(coll_valid_out), .coll_data_in(coll_data_in),
    .coll_done_in(coll_done_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int addr; int val; } exp_t;
  exp_t exp_q[$];
  int   model_val [GC];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic exp_err = 1'b0;
  logic spur_req = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ---------------- environment: BRAM and collision stage ----------------
  logic [8:0][7:0] mem [GC];
  logic [8:0][7:0] p1, p2;
  logic            cd_v [CDLY];
  logic [8:0][7:0] cd_d [CDLY];
  logic            s_we, s_cv, s_rst, s_spur;
  logic [AW-1:0]   s_waddr, s_raddr;
  logic [8:0][7:0] s_wdata, s_cd;

  initial begin
    s_we = 0; s_cv = 0; s_rst = 1; s_spur = 0;
    s_waddr = '0; s_raddr = '0; s_wdata = '0; s_cd = '0;
    forever begin
      @(negedge clk_in);
      s_we    = (bram_we_out === 1'b1);
      s_waddr = bram_waddr_out;
      s_wdata = bram_wdata_out;
      s_raddr = bram_raddr_out;
      s_cv    = (coll_valid_out === 1'b1);
      s_cd    = coll_data_out;
      s_rst   = rst_in;
      s_spur  = spur_req;
    end
  end

  initial begin
    logic [7:0] b;
    p1 = '0; p2 = '0;
    bram_rdata_in = '0; coll_done_in = 1'b0; coll_data_in = '0;
    for (int i = 0; i < CDLY; i++) begin cd_v[i] = 1'b0; cd_d[i] = '0; end
    for (int a = 0; a < GC; a++) begin b = 8'(a); mem[a] = {9{b}}; end
    forever begin
      tick();
      if (s_we) mem[s_waddr] = s_wdata;
      p2 = p1;
      p1 = mem[s_raddr];
      bram_rdata_in = p2;
      if (s_rst) begin
        for (int i = 0; i < CDLY; i++) begin cd_v[i] = 1'b0; cd_d[i] = '0; end
      end else begin
        for (int i = CDLY - 1; i > 0; i--) begin cd_v[i] = cd_v[i-1]; cd_d[i] = cd_d[i-1]; end
        cd_v[0] = s_cv;
        for (int k = 0; k < 9; k++) cd_d[0][k] = s_cd[k] + 8'd1;
      end
      coll_done_in = cd_v[CDLY-1] | s_spur;
      coll_data_in = cd_d[CDLY-1];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cv_total = 0;
  int wr_total = 0;
  int wr_in_sweep = 0;

  initial begin
    exp_t e;
    logic [7:0] ev;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        cv_total = wr_total;
        wr_in_sweep = 0;
      end else begin
        if (busy_out && wr_in_sweep == 0)
          chk("raddr_held_before_first_write", 72'(bram_raddr_out <= AW'(FD)), 72'(1));
        if (bram_we_out) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual_addr=%0d required=no_write", bram_waddr_out);
          end else begin
            e = exp_q.pop_front();
            ev = 8'(e.val);
            chk("write_addr", 72'(bram_waddr_out), 72'(e.addr));
            chk("write_data", bram_wdata_out, {9{ev}});
            if (wr_in_sweep == 0) chk("raddr_at_first_write", 72'(bram_raddr_out), 72'(FD));
          end
          wr_total++;
          wr_in_sweep++;
        end
        if (coll_valid_out) begin
          cv_total++;
          checks++;
          if (cv_total - wr_total > FD) begin
            errors++;
            $display("FAIL fifo_occupancy actual=%0d required_max=%0d", cv_total - wr_total, FD);
          end
        end
        if (done_out) begin
          done_cnt++;
          chk("done_after_last_write", 72'(exp_q.size()), 72'(0));
          chk("err_at_done", 72'(err_out), 72'(exp_err));
          wr_in_sweep = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_sweep();
    for (int a = 0; a < GC; a++) begin
      model_val[a] = (model_val[a] + 1) % 256;
      exp_q.push_back('{addr: a, val: model_val[a]});
    end
  endtask

  task automatic rollback();
    foreach (exp_q[i]) model_val[exp_q[i].addr] = (exp_q[i].val + 255) % 256;
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, 72'(busy_out), 72'(0));
    chk({tag, "_done"}, 72'(done_out), 72'(0));
    chk({tag, "_err"}, 72'(err_out), 72'(0));
    chk({tag, "_we"}, 72'(bram_we_out), 72'(0));
    chk({tag, "_cvalid"}, 72'(coll_valid_out), 72'(0));
    chk({tag, "_raddr"}, 72'(bram_raddr_out), 72'(0));
    chk({tag, "_waddr"}, 72'(bram_waddr_out), 72'(0));
    chk({tag, "_wdata"}, bram_wdata_out, 72'(0));
    chk({tag, "_cdata"}, coll_data_out, 72'(0));
  endtask

  task automatic run_sweep(input int extra_off);
    bit got;
    done_cnt = 0;
    start_in = 1'b1;
    push_sweep();
    tick();
    start_in = 1'b0;
    got = 0;
    for (int c = 1; c <= 300 && !got; c++) begin
      start_in = (c == extra_off);
      tick();
      if (done_out) got = 1;
    end
    start_in = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sweep_timeout actual=no_done required=done_within_300");
    end
    repeat (30) tick();
    chk("done_pulse_count", 72'(done_cnt), 72'(1));
  endtask

  initial begin
    for (int a = 0; a < GC; a++) model_val[a] = a;
    rst_in = 1'b1;
    repeat (3) tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_outputs_zero("reset");
    tick();

    // full sweep with a second start landing in DRAIN
    run_sweep(35);

    // spurious result while idle
    tick();
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    @(negedge clk_in);
    chk("spurious_we", 72'(bram_we_out), 72'(0));
    exp_err = 1'b1;
    @(negedge clk_in);
    chk("spurious_err", 72'(err_out), 72'(1));

    // randomized back-to-back sweeps with ignored start pulses
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      run_sweep(int'($urandom_range(1, 45)));
    end
    chk("err_sticky", 72'(err_out), 72'(1));

    // reset asserted at cycle 10 of a sweep
    tick();
    done_cnt = 0;
    start_in = 1'b1;
    push_sweep();
    tick();
    start_in = 1'b0;
    repeat (9) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    rollback();
    exp_err = 1'b0;
    @(negedge clk_in);
    check_outputs_zero("midreset");
    chk("midreset_no_done", 72'(done_cnt), 72'(0));
    tick();
    run_sweep(0);

    chk("queue_empty_end", 72'(exp_q.size()), 72'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/collide_scheduler.md
COLLIDE_SCHEDULER -- requirements
Module: collide_scheduler

Interface
REQ-001 SHALL have parameter GRID_CELLS, default 4800: number of lattice cells swept per pass.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13: width of the BRAM address, with 2**ADDR_WIDTH >= GRID_CELLS.
REQ-003 SHALL have parameter BRAM_LATENCY, default 2: cycles from read address to read data.
REQ-004 SHALL have parameter FIFO_DEPTH, default 32: entries in the address FIFO; power of two, >= 2.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start_in, input, 1 bit: a one-cycle pulse that begins a sweep.
REQ-008 SHALL have port busy_out, output, 1 bit: high from sweep accept until done.
REQ-009 SHALL have port done_out, output, 1 bit: one-cycle pulse at sweep completion.
REQ-010 SHALL have port err_out, output, 1 bit: sticky underflow flag.
REQ-011 SHALL have port bram_raddr_out, output, ADDR_WIDTH bits: BRAM read address.
REQ-012 SHALL have port bram_rdata_in, input, [8:0][7:0]: the 9 densities of one cell; element k at bits [8k+7:8k].
REQ-013 SHALL have port bram_waddr_out, output, ADDR_WIDTH bits: BRAM write address.
REQ-014 SHALL have port bram_wdata_out, output, [8:0][7:0]: write-back densities.
REQ-015 SHALL have port bram_we_out, output, 1 bit: BRAM write enable.
REQ-016 SHALL have port coll_data_out, output, [8:0][7:0]: densities to the collision stage.
REQ-017 SHALL have port coll_valid_out, output, 1 bit: coll_data_out is valid.
REQ-018 SHALL have port coll_data_in, input, [8:0][7:0]: collided densities from the collision stage.
REQ-019 SHALL have port coll_done_in, input, 1 bit: coll_data_in is valid.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN and FINISH.
- IDLE -> ISSUE on start_in.
- ISSUE -> DRAIN after the read for cell GRID_CELLS-1 is issued.
- DRAIN -> FINISH when reads in flight = 0, FIFO is empty and no coll_done_in is present this cycle.
- FINISH -> IDLE after one cycle.
REQ-021 SHALL ignore start_in in any state other than IDLE.
REQ-022 In ISSUE, SHALL issue one read per cycle, addresses 0 to GRID_CELLS-1 in order, subject to REQ-024.
REQ-023 SHALL track issued reads with a BRAM_LATENCY-deep valid shift register.
- When a valid emerges: coll_data_out = bram_rdata_in, coll_valid_out = 1 for that cycle, and the matching address is pushed into the FIFO.
REQ-024 SHALL stall issue (hold bram_raddr_out, no valid inserted) while FIFO occupancy + reads in flight >= FIFO_DEPTH.
- The collision stage has no backpressure, so the FIFO SHALL never overflow.
REQ-025 On coll_done_in = 1 with the FIFO non-empty, SHALL pop the head address and, in the same cycle, assert bram_we_out = 1 with bram_waddr_out = head and bram_wdata_out = coll_data_in (combinational write path).
REQ-026 On coll_done_in = 1 with the FIFO empty, SHALL keep bram_we_out = 0 and set err_out = 1; err_out SHALL clear only on rst_in.
REQ-027 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-028 In FINISH, done_out = 1 for exactly one cycle.
- busy_out = 1 in ISSUE, DRAIN and FINISH; 0 in IDLE.
REQ-029 coll_done_in SHALL be honoured in every state, including IDLE, so late results are written back.

Reset
REQ-030 SHALL apply rst_in synchronously, with priority over all other inputs, at any time including mid-sweep. On reset:
- state = IDLE
- FIFO pointers and occupancy = 0; valid shift register cleared
- busy_out, done_out, err_out, bram_we_out and coll_valid_out = 0
- bram_raddr_out and bram_waddr_out = 0; coll_data_out and bram_wdata_out = 0
- in-flight results are discarded

Verification
Bench setup: GRID_CELLS = 8, BRAM_LATENCY = 2, FIFO_DEPTH = 4. The collision stage is modelled as a fixed 22-cycle delay that adds 1 to each byte. BRAM cell a is preloaded with every byte = a.
REQ-031 Full sweep: start_in pulse -> 8 writes, addresses 0..7 in order, cell a written with all bytes a+1; done_out pulses once, after the last write; err_out = 0.
REQ-032 Backpressure: with the FIFO_DEPTH = 4 limit active -> bram_raddr_out holds at 4 until the first write-back, and occupancy + reads in flight never exceeds 4.
REQ-033 Spurious result: coll_done_in pulsed while in IDLE -> bram_we_out stays 0, err_out = 1 and remains 1 until rst_in.
REQ-034 Reset mid-sweep: rst_in asserted at cycle 10 of a sweep -> the next cycle has all outputs 0 and state IDLE; a following start_in completes all 8 cells correctly.
REQ-035 Start while busy: a second start_in during DRAIN -> ignored; exactly one done_out pulse.
REQ-036 Simultaneous push and pop: a cycle with both coll_valid_out = 1 and coll_done_in = 1 -> occupancy unchanged; pointer wrap past 3 produces correct write addresses.
